// File: rtl/pci_bus_monitor_if.sv
// PCI bus signals observed by the monitor, plus the record stream it produces.
// The master modport is the bus/consumer environment; the slave modport is the monitor.
interface pci_bus_monitor_if #(
    parameter int CNT_W = 16
) ();
    logic             frame;
    logic             irdy;
    logic             trdy;
    logic             stop;
    logic             devsel;
    logic             req64;
    logic             ack64;
    logic [31:0]      ad;
    logic [3:0]       c_be;

    logic             rec_valid;
    logic             rec_ready;
    logic [31:0]      rec_addr;
    logic [3:0]       rec_cmd;
    logic [CNT_W-1:0] rec_count;
    logic [2:0]       rec_term;
    logic             rec_64;

    modport master (
        output frame, irdy, trdy, stop, devsel, req64, ack64, ad, c_be, rec_ready,
        input  rec_valid, rec_addr, rec_cmd, rec_count, rec_term, rec_64
    );

    modport slave (
        input  frame, irdy, trdy, stop, devsel, req64, ack64, ad, c_be, rec_ready,
        output rec_valid, rec_addr, rec_cmd, rec_count, rec_term, rec_64
    );
endinterface

// File: rtl/pci_bus_monitor.sv
// Passive PCI transaction monitor: decodes each transaction, classifies its
// termination and queues one record per transaction in a fall-through FIFO.
module pci_bus_monitor #(
    parameter int FIFO_DEPTH     = 8,
    parameter int DEVSEL_TIMEOUT = 5,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pci_bus_monitor_if.slave bus,
    output logic [CNT_W-1:0] txn_total,
    output logic [CNT_W-1:0] drop_total,
    output logic             proto_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (DEVSEL_TIMEOUT < 1) ? 1 : $clog2(DEVSEL_TIMEOUT + 1);
    localparam logic [TW-1:0]    TO_LOAD  = TW'(DEVSEL_TIMEOUT);
    localparam logic [TW-1:0]    TO_ONE   = TW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [AW:0]      LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]      LVL_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [2:0] TERM_NORMAL = 3'd0;
    localparam logic [2:0] TERM_RETRY  = 3'd1;
    localparam logic [2:0] TERM_DISC   = 3'd2;
    localparam logic [2:0] TERM_TABORT = 3'd3;
    localparam logic [2:0] TERM_MABORT = 3'd4;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    typedef struct packed {
        logic [31:0]      addr;
        logic [3:0]       cmd;
        logic [CNT_W-1:0] count;
        logic [2:0]       term;
        logic             is64;
    } rec_t;

    state_t state_r, state_s;
    logic prev_frame_r, prev_irdy_r;
    logic [31:0] addr_r;
    logic [3:0] cmd_r;
    logic req64_r, ack64_seen_r, devsel_seen_r, stop_seen_r, devsel_at_stop_r, irdy_seen_r;
    logic [CNT_W-1:0] count_r;
    logic [TW-1:0] timeout_r;
    logic addr_phase_s, end_s, devsel_seen_s, stop_seen_s, devsel_at_stop_s, ack64_seen_s;
    logic proto_s;
    logic [2:0] term_s;
    rec_t rec_s, head_s;

    rec_t mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [AW:0] level_r, level_s;
    logic valid_r, push_s, pop_s, full_s, accept_s, drop_s;

    // Phase boundaries and this cycle's view of the sticky transaction flags.
    always_comb begin
        addr_phase_s     = (state_r == ST_IDLE) && !bus.frame && prev_frame_r && prev_irdy_r;
        end_s            = (state_r == ST_ACTIVE) && bus.frame && bus.irdy;
        devsel_seen_s    = devsel_seen_r || !bus.devsel;
        stop_seen_s      = stop_seen_r || !bus.stop;
        devsel_at_stop_s = bus.stop ? devsel_at_stop_r : !bus.devsel;
        ack64_seen_s     = ack64_seen_r || (!bus.devsel && !bus.ack64);
        // FRAME dropped without any IRDY, data or STOP although a target claimed it.
        proto_s = ((state_r == ST_IDLE) && ((bus.frame && !bus.irdy) || !bus.trdy || !bus.stop))
               || (end_s && !irdy_seen_r && (count_r == '0) && !stop_seen_s && devsel_seen_s);
    end

    // Next-state logic for the IDLE/ACTIVE transaction tracker.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   if (addr_phase_s) state_s = ST_ACTIVE; else state_s = ST_IDLE;
            ST_ACTIVE: if (end_s)        state_s = ST_IDLE;   else state_s = ST_ACTIVE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Termination classification in priority order, plus the record to push.
    always_comb begin
        term_s = TERM_NORMAL;
        if (!devsel_seen_s && (timeout_r == '0)) begin
            term_s = TERM_MABORT;
        end else if (stop_seen_s && !devsel_at_stop_s) begin
            term_s = TERM_TABORT;
        end else if (stop_seen_s && (count_r == '0)) begin
            term_s = TERM_RETRY;
        end else if (stop_seen_s) begin
            term_s = TERM_DISC;
        end else if (!devsel_seen_s) begin
            term_s = TERM_MABORT;
        end else begin
            term_s = TERM_NORMAL;
        end
        rec_s.addr  = addr_r;
        rec_s.cmd   = cmd_r;
        rec_s.count = count_r;
        rec_s.term  = term_s;
        rec_s.is64  = req64_r && ack64_seen_s;
    end

    // State register and per-transaction tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            prev_frame_r     <= 1'b1;
            prev_irdy_r      <= 1'b1;
            addr_r           <= 32'd0;
            cmd_r            <= 4'd0;
            req64_r          <= 1'b0;
            ack64_seen_r     <= 1'b0;
            devsel_seen_r    <= 1'b0;
            stop_seen_r      <= 1'b0;
            devsel_at_stop_r <= 1'b0;
            irdy_seen_r      <= 1'b0;
            count_r          <= '0;
            timeout_r        <= '0;
        end else begin
            state_r      <= state_s;
            prev_frame_r <= bus.frame;
            prev_irdy_r  <= bus.irdy;
            if (addr_phase_s) begin
                addr_r           <= bus.ad;
                cmd_r            <= bus.c_be;
                req64_r          <= !bus.req64;
                ack64_seen_r     <= 1'b0;
                devsel_seen_r    <= 1'b0;
                stop_seen_r      <= 1'b0;
                devsel_at_stop_r <= 1'b0;
                irdy_seen_r      <= 1'b0;
                count_r          <= '0;
                timeout_r        <= TO_LOAD;
            end else if (state_r == ST_ACTIVE) begin
                ack64_seen_r     <= ack64_seen_s;
                devsel_seen_r    <= devsel_seen_s;
                stop_seen_r      <= stop_seen_s;
                devsel_at_stop_r <= devsel_at_stop_s;
                irdy_seen_r      <= irdy_seen_r || !bus.irdy;
                if (!bus.irdy && !bus.trdy && (count_r != CNT_MAX)) count_r <= count_r + CNT_ONE;
                if (!devsel_seen_s && (timeout_r != '0)) timeout_r <= timeout_r - TO_ONE;
            end
        end
    end

    // FIFO control: a push while full is still accepted when the head pops.
    always_comb begin
        push_s   = end_s;
        pop_s    = valid_r && bus.rec_ready;
        full_s   = (level_r == LVL_FULL);
        accept_s = push_s && (!full_s || pop_s);
        drop_s   = push_s && full_s && !pop_s;
        case ({accept_s, pop_s})
            2'b10:   level_s = level_r + LVL_ONE;
            2'b01:   level_s = level_r - LVL_ONE;
            default: level_s = level_r;
        endcase
        if (valid_r) head_s = mem_r[rd_ptr_r]; else head_s = '0;
    end

    // Record storage, pointers, statistics and the sticky protocol flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            valid_r    <= 1'b0;
            txn_total  <= '0;
            drop_total <= '0;
            proto_err  <= 1'b0;
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r] <= rec_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
                if (txn_total != CNT_MAX) txn_total <= txn_total + CNT_ONE;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            if (drop_s && (drop_total != CNT_MAX)) drop_total <= drop_total + CNT_ONE;
            level_r <= level_s;
            valid_r <= (level_s != '0);
            if (proto_s) proto_err <= 1'b1;
        end
    end

    assign bus.rec_valid = valid_r;
    assign bus.rec_addr  = head_s.addr;
    assign bus.rec_cmd   = head_s.cmd;
    assign bus.rec_count = head_s.count;
    assign bus.rec_term  = head_s.term;
    assign bus.rec_64    = head_s.is64;
endmodule

// File: doc/pci_bus_monitor.md
Name: pci_bus_monitor

Overview:
- Passive PCI bus observer that instantiates alongside the arbiter, host master, memory target and DUT on the shared 32/64-bit PCI bus of the top-level bench.
- Decodes each bus transaction and classifies its termination.
- Pushes one record per transaction into an internal FIFO, drained by a valid/ready consumer: scoreboard, logger or DMA checker.
- Never drives any bus signal.

Parameters:
FIFO_DEPTH, 8, record FIFO entries; power of 2, minimum 2
DEVSEL_TIMEOUT, 5, clocks after the address phase without DEVSEL# before the transaction is classified master-abort
CNT_W, 16, width of the data-phase count and statistic counters (saturating)

Ports:
CLK  in  1  PCI clock
RESET  in  1  asynchronous active-low reset (PCI RST#)
FRAME  in  1  PCI FRAME#, active-low
IRDY  in  1  PCI IRDY#, active-low
TRDY  in  1  PCI TRDY#, active-low
STOP  in  1  PCI STOP#, active-low
DEVSEL  in  1  PCI DEVSEL#, active-low
REQ64  in  1  PCI REQ64#, active-low
ACK64  in  1  PCI ACK64#, active-low
AD  in  32  multiplexed address/data
C_BE  in  4  command / byte enables
rec_valid  out  1  FIFO head record available
rec_ready  in  1  consumer accepts head record
rec_addr  out  32  address-phase AD
rec_cmd  out  4  address-phase C_BE
rec_count  out  CNT_W  completed data phases
rec_term  out  3  0 normal, 1 retry, 2 disconnect, 3 target-abort, 4 master-abort
rec_64  out  1  REQ64# and ACK64# both asserted during the transaction
txn_total  out  CNT_W  records successfully pushed
drop_total  out  CNT_W  records lost to FIFO full
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Inputs are sampled only on the rising edge of CLK. No input synchronisation is required.
- RESET low, asynchronously:
  - rec_valid=0, and the FIFO is emptied.
  - txn_total=0, drop_total=0, proto_err=0.
  - State goes to IDLE.
  - rec_* data outputs read 0.
  - A transaction in flight is discarded and produces no record.
- States:
  - IDLE:
    - FRAME=0 with previous-cycle FRAME=1 and IRDY=1 marks the address phase.
    - Latch AD→addr, C_BE→cmd and REQ64, clear count/devsel_seen/stop_seen.
    - Go to ACTIVE and load the timeout counter with DEVSEL_TIMEOUT.
  - ACTIVE, every cycle:
    - DEVSEL=0 sets devsel_seen and ack64_seen|=!ACK64.
    - IRDY=0 and TRDY=0 increments count, saturating at all-ones.
    - STOP=0 latches stop_seen and records devsel_at_stop=!DEVSEL.
    - Without devsel_seen, the timeout counter decrements, floor 0.
  - End of ACTIVE: FRAME=1 and IRDY=1 sampled. Classify, push the record and return to IDLE the same cycle.
  - A new address phase is legal the cycle after the end of ACTIVE (back-to-back); no turnaround state is required.
- Classification, priority order:
  1. Master-abort: !devsel_seen and timeout reached 0.
  2. Target-abort: stop_seen and DEVSEL=1 at the STOP cycle.
  3. Retry: stop_seen and count==0.
  4. Disconnect: stop_seen.
  5. Otherwise normal.
  - Any other case without devsel_seen (timeout not yet reached) also records master-abort.
- rec_64 = latched REQ64 asserted AND ack64_seen.
- FIFO:
  - First-word fall-through: rec_* reflect the head whenever rec_valid=1.
  - Pop occurs when rec_valid and rec_ready.
  - Push while full with a simultaneous pop is accepted.
  - Push while full without a pop drops the record and increments drop_total (saturating). txn_total is not incremented.
  - Push when empty gives rec_valid=1 on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- proto_err is set (sticky until reset) on any of:
  - IRDY=0 while in IDLE with FRAME=1.
  - FRAME=1 with IRDY=1 before any IRDY=0 in ACTIVE and count==0 with no STOP and with devsel_seen. This is a master dropping FRAME before asserting IRDY.
  - TRDY=0 or STOP=0 while in IDLE.
- Latency: a record is visible at rec_valid 1 clock after the transaction end cycle.

Test Plan:
- Single write: MEM write (cmd 7) to 0x1000_0000, 1 data phase, DEVSEL on the 2nd clock, no STOP → one record: addr 0x10000000, cmd 7, count 1, term 0, rec_64 0. txn_total=1.
- Burst and 64-bit: 8-phase MEM read-line with REQ64#/ACK64#, TRDY wait-stated on phases 3 and 6 → count 8, term 0, rec_64 1.
- Retry and disconnect: STOP with TRDY=1 on the first data phase → term 1, count 0. STOP with TRDY=0 on phase 4 → term 2, count 4.
- Aborts: access to an unclaimed address, no DEVSEL for 6 clocks → term 4. DEVSEL deasserted with STOP asserted → term 3.
- FIFO overflow: 10 transactions with rec_ready=0 and FIFO_DEPTH=8 → rec_valid=1, drop_total=2, txn_total=8. Then drain with rec_ready=1 → 8 records in order, rec_valid falls after the 8th pop.
- Reset mid-burst: assert RESET on phase 3 of a burst → rec_valid=0, counters 0 immediately (asynchronous). After release, the next transaction is recorded normally. Injecting IRDY=0 with the bus idle sets proto_err=1.
